// File: rtl/sensor_pkg.sv
// Shared encodings, constants and state types for the sensor command path.
// Frame validation helpers are used by both the main and the shadow frame assembler.
package sensor_pkg;

  localparam logic [1:0] REQ_HUM    = 2'b00;
  localparam logic [1:0] REQ_TEMP   = 2'b01;
  localparam logic [1:0] REQ_STATUS = 2'b10;
  localparam logic [1:0] REQ_STOP   = 2'b11;

  localparam logic [7:0] CMD_HUM    = 8'h01;
  localparam logic [7:0] CMD_TEMP   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_STOP   = 8'h04;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CMD  = 2'b01;
  localparam logic [1:0] ERR_ADDR = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_CMD,
    S_WAIT_ADDR,
    S_CHECK,
    S_ISSUE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [1:0] cmd_req(input logic [7:0] cmd);
    case (cmd)
      CMD_TEMP:   return REQ_TEMP;
      CMD_STATUS: return REQ_STATUS;
      CMD_STOP:   return REQ_STOP;
      default:    return REQ_HUM;
    endcase
  endfunction

  // Bad command outranks bad address.
  function automatic logic [1:0] frame_chk(
    input logic [7:0] cmd,
    input logic [7:0] addr,
    input logic [8:0] ns
  );
    if (cmd < CMD_HUM || cmd > CMD_STOP) return ERR_CMD;
    if ({1'b0, addr} >= ns) return ERR_ADDR;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/sensor_cmd_receiver_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling, LSB first.
// Bytes with a low stop bit are dropped without any indication.
module uart_rx
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_uart,
  output logic [7:0] rx_byte,
  output logic       rx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q;
  rx_state_t       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            done_q, done_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          st_d   = RX_IDLE;
          done_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= rx_uart;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
    end
  end

  assign rx_byte = sh_q;
  assign rx_done = done_q;

endmodule

// File: rtl/sensor_cmd_receiver.sv
// Host command frame receiver feeding the sensor FSM over valid/ready.
// Optional one-entry skid buffer for frames arriving during a stall: CMD_SKID_EN.
module sensor_cmd_receiver
  import sensor_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 9600,
  parameter int ADDR_W         = 5,
  parameter int NUM_SENSORS    = 32,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_uart,
  output logic [1:0]        request,
  output logic [ADDR_W-1:0] sensor_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              overrun,
  output logic              busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0] NS = 9'(NUM_SENSORS);

  logic [7:0] rx_byte;
  logic       rx_done;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock   (clock),
    .reset   (reset),
    .rx_uart (rx_uart),
    .rx_byte (rx_byte),
    .rx_done (rx_done)
  );

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        req_q, req_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              err_v_q, err_v_d;
  logic [1:0]        err_c_q, err_c_d;
  logic              ovr_q, ovr_d;
  logic              sh_wait_q, sh_wait_d;
  logic [7:0]        sh_cmd_q, sh_cmd_d;
`ifdef CMD_SKID_EN
  logic              skid_full_q, skid_full_d;
  logic [1:0]        skid_req_q, skid_req_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
`endif

  logic [1:0] chk_e, sh_err;
  logic       tmo_hit, xfer, sh_ok, leave;

  assign chk_e   = frame_chk(cmd_q, addr_q, NS);
  assign sh_err  = frame_chk(sh_cmd_q, rx_byte, NS);
  assign tmo_hit = (tmo_q == TMO_LAST) && !rx_done;
  assign xfer    = (state_q == S_ISSUE) && req_ready;
  assign sh_ok   = (state_q == S_ISSUE) && sh_wait_q && rx_done
                && (sh_err == ERR_NONE);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    saddr_d   = saddr_q;
    err_v_d   = 1'b0;
    err_c_d   = err_c_q;
    ovr_d     = 1'b0;
    sh_wait_d = sh_wait_q;
    sh_cmd_d  = sh_cmd_q;
    leave     = 1'b0;
`ifdef CMD_SKID_EN
    skid_full_d = skid_full_q;
    skid_req_d  = skid_req_q;
    skid_addr_d = skid_addr_q;
`endif
    unique case (state_q)
      S_WAIT_CMD: begin
        if (rx_done) begin
          cmd_d   = rx_byte;
          tmo_d   = '0;
          state_d = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        if (rx_done) begin
          addr_d  = rx_byte;
          state_d = S_CHECK;
        end else if (tmo_hit) begin
          err_v_d = 1'b1;
          err_c_d = ERR_TMO;
          state_d = S_WAIT_CMD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (chk_e != ERR_NONE) begin
          err_v_d = 1'b1;
          err_c_d = chk_e;
          state_d = S_WAIT_CMD;
        end else begin
          req_d   = cmd_req(cmd_q);
          saddr_d = addr_q[ADDR_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Shadow assembler runs while the current request is outstanding.
        if (!sh_wait_q) begin
          if (rx_done) begin
            sh_cmd_d  = rx_byte;
            sh_wait_d = 1'b1;
            tmo_d     = '0;
          end
        end else if (rx_done) begin
          sh_wait_d = 1'b0;
          if (sh_err != ERR_NONE) begin
            err_v_d = 1'b1;
            err_c_d = sh_err;
          end
        end else if (tmo_hit) begin
          sh_wait_d = 1'b0;
          err_v_d   = 1'b1;
          err_c_d   = ERR_TMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`ifdef CMD_SKID_EN
        if (xfer && skid_full_q) begin
          req_d       = skid_req_q;
          saddr_d     = skid_addr_q;
          skid_full_d = sh_ok;
          if (sh_ok) begin
            skid_req_d  = cmd_req(sh_cmd_q);
            skid_addr_d = rx_byte[ADDR_W-1:0];
          end
        end else if (xfer && sh_ok) begin
          req_d   = cmd_req(sh_cmd_q);
          saddr_d = rx_byte[ADDR_W-1:0];
        end else if (xfer) begin
          leave = 1'b1;
        end else if (sh_ok && skid_full_q) begin
          ovr_d = 1'b1;
        end else if (sh_ok) begin
          skid_full_d = 1'b1;
          skid_req_d  = cmd_req(sh_cmd_q);
          skid_addr_d = rx_byte[ADDR_W-1:0];
        end
`else
        ovr_d = sh_ok;
        leave = xfer;
`endif
        // A half-received shadow frame continues in the main path.
        if (leave) begin
          state_d   = sh_wait_d ? S_WAIT_ADDR : S_WAIT_CMD;
          cmd_d     = sh_cmd_d;
          sh_wait_d = 1'b0;
        end
      end
    endcase
  end

  assign vld_d  = (state_d == S_ISSUE);
  assign busy_d = (state_d != S_WAIT_CMD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_WAIT_CMD;
      cmd_q     <= '0;
      addr_q    <= '0;
      tmo_q     <= '0;
      req_q     <= REQ_HUM;
      saddr_q   <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_v_q   <= 1'b0;
      err_c_q   <= ERR_NONE;
      ovr_q     <= 1'b0;
      sh_wait_q <= 1'b0;
      sh_cmd_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      saddr_q   <= saddr_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      err_v_q   <= err_v_d;
      err_c_q   <= err_c_d;
      ovr_q     <= ovr_d;
      sh_wait_q <= sh_wait_d;
      sh_cmd_q  <= sh_cmd_d;
    end
  end

`ifdef CMD_SKID_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_full_q <= 1'b0;
      skid_req_q  <= REQ_HUM;
      skid_addr_q <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_req_q  <= skid_req_d;
      skid_addr_q <= skid_addr_d;
    end
  end
`endif

  assign request     = req_q;
  assign sensor_addr = saddr_q;
  assign req_valid   = vld_q;
  assign err_valid   = err_v_q;
  assign err_code    = err_c_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sensor_cmd_receiver.sv
// Self-checking bench for sensor_cmd_receiver with a bit-accurate UART driver.
// Expected frames come from a frame-level reference model of the command rules.
module tb_sensor_cmd_receiver;

  localparam int CLK_FREQ = 160_000;
  localparam int BAUD     = 10_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 5;
  localparam int NUM      = 32;
  localparam int TMO      = 2000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rx_uart = 1'b1;
  logic              req_ready = 1'b0;
  logic [1:0]        request;
  logic [ADDR_W-1:0] sensor_addr;
  logic              req_valid;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              overrun;
  logic              busy;

  sensor_cmd_receiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W),
    .NUM_SENSORS(NUM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .rx_uart(rx_uart),
    .request(request), .sensor_addr(sensor_addr),
    .req_valid(req_valid), .req_ready(req_ready),
    .err_valid(err_valid), .err_code(err_code),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [ADDR_W+1:0] got_req[$];
  logic [1:0]        got_err[$];
  int ovr_cnt = 0, vld_cycles = 0;
  int rxd_cyc = 0, first_vld_cyc = 0, err_cyc = 0;
  logic vld_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (req_valid && req_ready) got_req.push_back({request, sensor_addr});
      if (req_valid && !vld_prev) first_vld_cyc = cyc;
      if (req_valid) vld_cycles++;
      if (dut.rx_done) rxd_cyc = cyc;
      if (err_valid) begin
        got_err.push_back(err_code);
        err_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
    end
    vld_prev = req_valid;
  end

  function automatic void model(input logic [7:0] c, input logic [7:0] a,
                                output bit ok, output logic [1:0] rq,
                                output logic [1:0] ec);
    ok = 0; rq = 2'b00; ec = 2'b00;
    case (c)
      8'h01: rq = 2'b00;
      8'h02: rq = 2'b01;
      8'h03: rq = 2'b10;
      8'h04: rq = 2'b11;
      default: begin ec = 2'b01; return; end
    endcase
    if (int'(a) >= NUM) begin ec = 2'b10; return; end
    ok = 1;
  endfunction

  task automatic drive_bit(input logic v);
    rx_uart = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx_uart = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    got_req.delete();
    got_err.delete();
    ovr_cnt = 0;
    vld_cycles = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clock);
      if (!busy && !req_valid) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL idle_wait: busy=%b req_valid=%b required idle", busy, req_valid);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({request, sensor_addr, req_valid, err_valid, err_code, overrun, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b addr=%0d v=%b ev=%b ec=%b ov=%b busy=%b required all 0",
               request, sensor_addr, req_valid, err_valid, err_code, overrun, busy);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    req_ready = 1'b1;
    clear_mon();
    send_frame(8'h02, 8'h05);
    wait_idle();
    checks++;
    if (got_req.size() != 1 || got_req[0] !== {2'b01, 5'd5}) begin
      failures++;
      $display("FAIL basic_issue: got n=%0d first=%h required 1 x %h",
               got_req.size(), got_req.size() ? got_req[0] : '0, {2'b01, 5'd5});
    end
    checks++;
    if (first_vld_cyc - rxd_cyc != 2) begin
      failures++;
      $display("FAIL basic_latency: got %0d required 2", first_vld_cyc - rxd_cyc);
    end
    checks++;
    if (vld_cycles != 1 || got_err.size() != 0) begin
      failures++;
      $display("FAIL basic_pulse: got valid_cycles=%0d errs=%0d required 1 and 0",
               vld_cycles, got_err.size());
    end
  endtask

  task automatic test_errors();
    logic [7:0] c[3] = '{8'h07, 8'h01, 8'h07};
    logic [7:0] a[3] = '{8'h00, 8'h20, 8'h40};
    logic [1:0] e[3] = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      clear_mon();
      send_frame(c[i], a[i]);
      wait_idle();
      checks++;
      if (got_err.size() != 1 || got_err[0] !== e[i] || vld_cycles != 0) begin
        failures++;
        $display("FAIL err_frame%0d: got n=%0d code=%b valid_cycles=%0d required 1 x %b, 0",
                 i, got_err.size(), got_err.size() ? got_err[0] : 2'b00, vld_cycles, e[i]);
      end
    end
    checks++;
    if (err_code !== 2'b01) begin
      failures++;
      $display("FAIL err_code_hold: got %b required 01", err_code);
    end
  endtask

  task automatic test_timeout();
    bit seen = 0;
    clear_mon();
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (got_err.size() != 0) seen = 1;
    end
    checks++;
    if (!seen || got_err[0] !== 2'b11) begin
      failures++;
      $display("FAIL timeout_code: seen=%b code=%b required 11", seen,
               seen ? got_err[0] : 2'b00);
    end
    checks++;
    if (err_cyc - rxd_cyc < TMO || err_cyc - rxd_cyc > TMO + 2) begin
      failures++;
      $display("FAIL timeout_delay: got %0d required %0d..%0d",
               err_cyc - rxd_cyc, TMO, TMO + 2);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got %b required 0", busy);
    end
    @(posedge clock);
    #1;
    clear_mon();
    send_frame(8'h03, 8'h01);
    wait_idle();
    checks++;
    if (got_req.size() != 1 || got_req[0] !== {2'b10, 5'd1}) begin
      failures++;
      $display("FAIL timeout_recover: got n=%0d first=%h required 1 x %h",
               got_req.size(), got_req.size() ? got_req[0] : '0, {2'b10, 5'd1});
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W+1:0] exp[$];
    int exp_ovr;
    req_ready = 1'b0;
    clear_mon();
    send_frame(8'h02, 8'h03);
    send_frame(8'h01, 8'h02);
`ifdef CMD_SKID_EN
    exp_ovr = 0;
`else
    exp_ovr = 1;
`endif
    checks++;
    if (ovr_cnt != exp_ovr) begin
      failures++;
      $display("FAIL stall_overrun1: got %0d required %0d", ovr_cnt, exp_ovr);
    end
    @(negedge clock);
    checks++;
    if (req_valid !== 1'b1 || {request, sensor_addr} !== {2'b01, 5'd3}) begin
      failures++;
      $display("FAIL stall_hold: got v=%b %h required 1 %h",
               req_valid, {request, sensor_addr}, {2'b01, 5'd3});
    end
    @(posedge clock);
    #1;
    send_frame(8'h09, 8'h01);
    checks++;
    if (got_err.size() != 1 || got_err[0] !== 2'b01) begin
      failures++;
      $display("FAIL stall_shadow_err: got n=%0d code=%b required 1 x 01",
               got_err.size(), got_err.size() ? got_err[0] : 2'b00);
    end
    exp.push_back({2'b01, 5'd3});
`ifdef CMD_SKID_EN
    exp.push_back({2'b00, 5'd2});
    send_frame(8'h03, 8'h04);
    checks++;
    if (ovr_cnt != 1) begin
      failures++;
      $display("FAIL stall_overrun2: got %0d required 1", ovr_cnt);
    end
`endif
    checks++;
    if (got_req.size() != 0) begin
      failures++;
      $display("FAIL stall_no_xfer: got %0d required 0", got_req.size());
    end
    req_ready = 1'b1;
    wait_idle();
    checks++;
    if (got_req.size() != exp.size()) begin
      failures++;
      $display("FAIL stall_count: got %0d required %0d", got_req.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (got_req[i] !== exp[i]) begin
          failures++;
          $display("FAIL stall_req%0d: got %h required %h", i, got_req[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_byte(8'h04, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before: got %b required 1", busy);
    end
    reset = 1'b1;
    rx_uart = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({request, sensor_addr, req_valid, err_valid, err_code, overrun, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got req=%b addr=%0d v=%b ev=%b ec=%b ov=%b busy=%b required all 0",
               request, sensor_addr, req_valid, err_valid, err_code, overrun, busy);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (12 * CPB) @(posedge clock);
    #1;
    clear_mon();
    send_frame(8'h04, 8'h00);
    wait_idle();
    checks++;
    if (got_req.size() != 1 || got_req[0] !== {2'b11, 5'd0} || got_err.size() != 0) begin
      failures++;
      $display("FAIL midreset_recover: got n=%0d first=%h errs=%0d required 1 x %h",
               got_req.size(), got_req.size() ? got_req[0] : '0, got_err.size(), {2'b11, 5'd0});
    end
  endtask

  task automatic test_framing();
    clear_mon();
    send_byte(8'h01, 1'b0);
    repeat (4 * CPB) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || got_err.size() != 0) begin
      failures++;
      $display("FAIL framing_drop: got busy=%b errs=%0d required 0 0", busy, got_err.size());
    end
    @(posedge clock);
    #1;
    send_frame(8'h02, 8'h07);
    wait_idle();
    checks++;
    if (got_req.size() != 1 || got_req[0] !== {2'b01, 5'd7}) begin
      failures++;
      $display("FAIL framing_next: got n=%0d first=%h required 1 x %h",
               got_req.size(), got_req.size() ? got_req[0] : '0, {2'b01, 5'd7});
    end
  endtask

  task automatic test_random();
    logic [ADDR_W+1:0] exp_req[$];
    logic [1:0] exp_err[$];
    logic [7:0] c, a;
    logic [1:0] rq, ec;
    bit ok;
    int r;
    clear_mon();
    req_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 9);
      c = (r < 6) ? 8'(1 + r % 4) : 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 47));
      model(c, a, ok, rq, ec);
      if (ok) exp_req.push_back({rq, a[ADDR_W-1:0]});
      else exp_err.push_back(ec);
      send_frame(c, a);
      wait_idle();
    end
    checks++;
    if (got_req.size() != exp_req.size() || got_err.size() != exp_err.size()) begin
      failures++;
      $display("FAIL rand_counts: got req=%0d err=%0d required req=%0d err=%0d",
               got_req.size(), got_err.size(), exp_req.size(), exp_err.size());
    end else begin
      foreach (exp_req[i]) begin
        checks++;
        if (got_req[i] !== exp_req[i]) begin
          failures++;
          $display("FAIL rand_req%0d: got %h required %h", i, got_req[i], exp_req[i]);
        end
      end
      foreach (exp_err[i]) begin
        checks++;
        if (got_err[i] !== exp_err[i]) begin
          failures++;
          $display("FAIL rand_err%0d: got %b required %b", i, got_err[i], exp_err[i]);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_framing();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
